// File: rtl/pipe_mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// controller states and the default datapath width.
package pipe_mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        FIXUP   = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_mdu_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x.
// Used to take operand magnitudes and to restore result signs.
module pipe_mdu_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/pipe_mdu.sv
// pipe_mdu: iterative multiply/divide unit with architectural HI/LO.
// Signed ops run on magnitudes; the sign is restored in a single FIXUP
// cycle. STEPS must equal WIDTH (one result bit per iteration).
module pipe_mdu
    import pipe_mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int STEPS = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             rd_hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mdu_out
);

    localparam int            CW   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_e               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;       // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;       // dividend shifts out the top, quotient bits in the bottom
    logic                 sign_a;
    logic                 sign_b;
    logic                 is_div;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_fit;

    assign signed_op = (op == MULT) || (op == DIV);

    // Operand magnitudes at capture; unsigned ops pass through untouched.
    pipe_mdu_abs #(.W(WIDTH)) u_abs_a (
        .x   (a),
        .neg (signed_op & a[WIDTH-1]),
        .y   (a_mag)
    );

    pipe_mdu_abs #(.W(WIDTH)) u_abs_b (
        .x   (b),
        .neg (signed_op & b[WIDTH-1]),
        .y   (b_mag)
    );

    // Sign restoration; sign flags are only ever set for signed ops.
    pipe_mdu_abs #(.W(2*WIDTH)) u_fix_prod (
        .x   (acc),
        .neg (sign_a ^ sign_b),
        .y   (prod_fix)
    );

    pipe_mdu_abs #(.W(WIDTH)) u_fix_quo (
        .x   (quo),
        .neg (sign_a ^ sign_b),
        .y   (quo_fix)
    );

    pipe_mdu_abs #(.W(WIDTH)) u_fix_rem (
        .x   (rem),
        .neg (sign_a),
        .y   (rem_fix)
    );

    // One shift-add step: add multiplicand into the upper half when the
    // current multiplier bit is set; the carry becomes the new top bit.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

    // One restoring step: bring the next dividend bit into the remainder.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_fit   = div_shift >= {1'b0, divisor};

    assign mdu_out = rd_hi ? hi : lo;

    // Controller and datapath: launch, iterate, fix up signs, commit HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            is_div  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                // Flush drops the in-flight op without touching HI/LO.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            case (op)
                                MTHI: begin
                                    hi   <= a;
                                    done <= 1'b1;
                                end
                                MTLO: begin
                                    lo   <= a;
                                    done <= 1'b1;
                                end
                                MULT, MULTU: begin
                                    mcand  <= a_mag;
                                    acc    <= {{WIDTH{1'b0}}, b_mag};
                                    sign_a <= signed_op & a[WIDTH-1];
                                    sign_b <= signed_op & b[WIDTH-1];
                                    is_div <= 1'b0;
                                    cnt    <= '0;
                                    busy   <= 1'b1;
                                    state  <= MUL_RUN;
                                end
                                DIV, DIVU: begin
                                    if (b == '0) begin
                                        // Divide by zero completes at once with fixed results.
                                        lo   <= '1;
                                        hi   <= a;
                                        done <= 1'b1;
                                    end else begin
                                        quo     <= a_mag;
                                        divisor <= b_mag;
                                        rem     <= '0;
                                        sign_a  <= signed_op & a[WIDTH-1];
                                        sign_b  <= signed_op & b[WIDTH-1];
                                        is_div  <= 1'b1;
                                        cnt     <= '0;
                                        busy    <= 1'b1;
                                        state   <= DIV_RUN;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL_RUN: begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) state <= FIXUP;
                    end
                    DIV_RUN: begin
                        rem <= WIDTH'(div_fit ? div_shift - {1'b0, divisor} : div_shift);
                        quo <= {quo[WIDTH-2:0], div_fit};
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) state <= FIXUP;
                    end
                    FIXUP: begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_mdu.sv
// Testbench for pipe_mdu: cycle-level reference model plus directed tests.
module tb_pipe_mdu;
    import pipe_mdu_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    op_e         op    = MULT;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        abort = 1'b0;
    logic        rd_hi = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_mdu #(.WIDTH(32), .STEPS(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .abort   (abort),
        .rd_hi   (rd_hi),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .mdu_out (mdu_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input op_e o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r, p;
        logic [63:0] res;
        sx  = $signed(x);
        sy  = $signed(y);
        res = '0;
        case (o)
            MULT: begin
                p   = sx * sy;
                res = p;
            end
            MULTU: res = {32'b0, x} * {32'b0, y};
            DIV: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            DIVU: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Reference model: 33 busy cycles for iterative ops, immediate for the rest.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (abort) m_busy <= 1'b0;
                else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end else m_left <= m_left - 1;
            end else if (start && !abort) begin
                case (op)
                    MTHI: begin m_hi <= a; m_done <= 1'b1; end
                    MTLO: begin m_lo <= a; m_done <= 1'b1; end
                    MULT, MULTU, DIV, DIVU: begin
                        if ((op == DIV || op == DIVU) && b == 0) begin
                            {m_hi, m_lo} <= ref_op(op, a, b);
                            m_done <= 1'b1;
                        end else begin
                            {p_hi, p_lo} <= ref_op(op, a, b);
                            m_busy <= 1'b1;
                            m_left <= 33;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("mdu_out", mdu_out, rd_hi ? m_hi : m_lo);
        chk("busy_done_excl", busy & done, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input op_e o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < limit) begin
            if (busy) bcnt++;
            tick();
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required<%0d", cyc, limit);
        end
    endtask

    task automatic run_op(input op_e o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output int bcnt);
        issue(o, x, y);
        wait_done(60, cyc, bcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bcnt;
        bit seen;

        // Pin the model itself with hand-computed results.
        chk("model_multu", ref_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_mult", ref_op(MULT, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_div", ref_op(DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_div_ovf", ref_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        // Reset state
        tick();
        tick();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: MULTU max*max, latency and busy length
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcnt);
        chk("t1_latency", cyc, 33);
        chk("t1_busy_cycles", bcnt, 33);
        chk("t1_hi", hi, 32'hFFFF_FFFE);
        chk("t1_lo", lo, 32'h0000_0001);
        tick();
        chk("t1_done_one_cycle", done, 1'b0);

        // 2: MULT -3*7, read LO through mdu_out in the done cycle
        rd_hi = 1'b0;
        run_op(MULT, 32'hFFFF_FFFD, 32'd7, cyc, bcnt);
        chk("t2_hi", hi, 32'hFFFF_FFFF);
        chk("t2_mdu_out_lo", mdu_out, 32'hFFFF_FFEB);

        // 3: signed division, including overflow and negative divisor
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, cyc, bcnt);
        chk("t3_lo", lo, 32'hFFFF_FFFD);
        chk("t3_hi", hi, 32'hFFFF_FFFF);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt);
        chk("t3_ovf_lo", lo, 32'h8000_0000);
        chk("t3_ovf_hi", hi, 32'h0);
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, cyc, bcnt);
        chk("t3_negdiv_lo", lo, 32'hFFFF_FFFD);
        chk("t3_negdiv_hi", hi, 32'd1);
        run_op(DIVU, 32'd100, 32'd7, cyc, bcnt);
        chk("t3_divu_lo", lo, 32'd14);
        chk("t3_divu_hi", hi, 32'd2);
        run_op(MULT, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt);
        chk("t3_mult_min_hi", hi, 32'h0);
        chk("t3_mult_min_lo", lo, 32'h8000_0000);

        // 4: DIVU by zero completes immediately
        run_op(DIVU, 32'd5, 32'd0, cyc, bcnt);
        chk("t4_latency", cyc, 0);
        chk("t4_busy_cycles", bcnt, 0);
        chk("t4_lo", lo, 32'hFFFF_FFFF);
        chk("t4_hi", hi, 32'd5);
        tick();
        chk("t4_done_one_cycle", done, 1'b0);

        // 5a: start while busy is ignored
        issue(MULTU, 32'd3, 32'd4);
        repeat (4) tick();
        start = 1'b1;
        op    = MULTU;
        a     = 32'd100;
        b     = 32'd100;
        tick();
        start = 1'b0;
        wait_done(60, cyc, bcnt);
        chk("t5_ignore_hi", hi, 32'd0);
        chk("t5_ignore_lo", lo, 32'd12);

        // 5b: abort mid-op cancels without HI/LO update
        issue(MULTU, 32'd7, 32'd7);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 1'b0);
        chk("t5_abort_done", done, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("t5_abort_no_done", seen, 1'b0);
        chk("t5_abort_hi", hi, 32'd0);
        chk("t5_abort_lo", lo, 32'd12);

        // abort and start together in IDLE: op not launched
        start = 1'b1;
        abort = 1'b1;
        op    = MTHI;
        a     = 32'hDEAD;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_abort_start_done", done, 1'b0);
        chk("t5_abort_start_hi", hi, 32'd0);

        // 5c: asynchronous reset mid-op
        issue(MULTU, 32'd9, 32'd9);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_hi", hi, 32'd0);
        chk("t5_rst_lo", lo, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 6: MTHI then MTLO back to back
        start = 1'b1;
        op    = MTHI;
        a     = 32'h1234;
        tick();
        op    = MTLO;
        a     = 32'h5678;
        rd_hi = 1'b1;
        #1;
        chk("t6_mthi_done", done, 1'b1);
        chk("t6_mfhi", mdu_out, 32'h1234);
        tick();
        start = 1'b0;
        rd_hi = 1'b0;
        #1;
        chk("t6_mtlo_done", done, 1'b1);
        chk("t6_mflo", mdu_out, 32'h5678);
        chk("t6_hi_kept", hi, 32'h1234);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
